// File: rtl/pe_accu_lanes.sv
// Per-lane PE accumulator: merges hi/lo partial products, accumulates with saturation,
// and drains a snapshot of all lanes through a valid/ready port, OUT_PAR lanes per beat.
module pe_accu_lanes #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned IN_W    = 16,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned OUT_PAR = 1,
  localparam int unsigned BEATS  = LANES / OUT_PAR,
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_mode,
  input  logic [1:0]               cfg_preci,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*2*IN_W-1:0]  in_data,
  input  logic                     in_first,
  input  logic                     in_accu,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_PAR*ACC_W-1:0] out_data,
  output logic [BEAT_W-1:0]        out_beat,
  output logic                     out_last,
  output logic [OUT_PAR-1:0]       out_ovf,
  output logic                     busy
);

  localparam int unsigned SUM_W = IN_W + 5;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]               state, state_nxt;
  logic [BEAT_W-1:0]        beat_nxt;
  logic                     s1_valid, s1_first, s1_accu, s1_last;
  logic signed [SUM_W-1:0]  sum_c   [LANES];
  logic signed [SUM_W-1:0]  s1_sum  [LANES];
  logic signed [ACC_W-1:0]  acc     [LANES];
  logic signed [ACC_W-1:0]  acc_nxt [LANES];
  logic signed [ACC_W-1:0]  acc_ext [LANES];
  logic        [ACC_W:0]    acc_wide[LANES];
  logic [LANES-1:0]         ovf, ovf_nxt;
  logic [LANES*ACC_W-1:0]   buf_data, snap_data;
  logic [LANES-1:0]         buf_ovf, snap_ovf;
  logic                     snap_need, stall, accept, snapshot;

  assign snap_need = s1_valid && (cfg_mode || s1_last);
  assign stall     = snap_need && (state == DRAIN) && !(out_last && out_ready);
  assign in_ready  = !stall;
  assign accept    = in_valid && in_ready;
  assign snapshot  = snap_need && !stall;
  assign out_valid = (state == DRAIN);
  assign out_last  = (state == DRAIN) && (out_beat == BEAT_W'(BEATS - 1));
  assign busy      = s1_valid || (state == DRAIN);

  // Merge hi/lo halves; non-int8xint4 modes weight hi by 16.
  always_comb begin
    for (int k = 0; k < int'(LANES); k++) begin
      if (cfg_preci == 2'b00)
        sum_c[k] = SUM_W'($signed(in_data[(int'(LANES)+k)*int'(IN_W) +: IN_W]))
                 + SUM_W'($signed(in_data[k*int'(IN_W) +: IN_W]));
      else
        sum_c[k] = (SUM_W'($signed(in_data[(int'(LANES)+k)*int'(IN_W) +: IN_W])) <<< 4)
                 + SUM_W'($signed(in_data[k*int'(IN_W) +: IN_W]));
    end
  end

  // Accumulator update with saturation, plus the snapshot image for the drain buffer.
  always_comb begin
    ovf_nxt   = ovf;
    snap_ovf  = '0;
    snap_data = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      acc_ext[k]  = ACC_W'(s1_sum[k]);
      acc_wide[k] = {acc[k][ACC_W-1], acc[k]} + {acc_ext[k][ACC_W-1], acc_ext[k]};
      acc_nxt[k]  = acc[k];
      if (s1_first) begin
        acc_nxt[k] = acc_ext[k];
        ovf_nxt[k] = 1'b0;
      end else if (s1_accu) begin
        if (acc_wide[k][ACC_W] != acc_wide[k][ACC_W-1]) begin
          acc_nxt[k] = acc_wide[k][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
          ovf_nxt[k] = 1'b1;
        end else begin
          acc_nxt[k] = acc_wide[k][ACC_W-1:0];
        end
      end
      snap_data[k*int'(ACC_W) +: ACC_W] = cfg_mode ? acc_ext[k] : acc_nxt[k];
      snap_ovf[k] = cfg_mode ? 1'b0 : ovf_nxt[k];
    end
  end

  // Drain sequencing; a snapshot on the final handshake restarts at beat 0.
  always_comb begin
    state_nxt = state;
    beat_nxt  = out_beat;
    if ((state == DRAIN) && out_ready) begin
      if (out_last) state_nxt = IDLE;
      else          beat_nxt  = out_beat + BEAT_W'(1);
    end
    if (snapshot) begin
      state_nxt = DRAIN;
      beat_nxt  = '0;
    end
  end

  always_comb begin
    out_data = '0;
    out_ovf  = '0;
    for (int b = 0; b < int'(BEATS); b++) begin
      if (out_beat == BEAT_W'(b)) begin
        out_data = buf_data[b*int'(OUT_PAR*ACC_W) +: OUT_PAR*ACC_W];
        out_ovf  = buf_ovf[b*int'(OUT_PAR) +: OUT_PAR];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      out_beat <= '0;
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_accu  <= 1'b0;
      s1_last  <= 1'b0;
      ovf      <= '0;
      buf_data <= '0;
      buf_ovf  <= '0;
      for (int k = 0; k < int'(LANES); k++) begin
        s1_sum[k] <= '0;
        acc[k]    <= '0;
      end
    end else begin
      state    <= state_nxt;
      out_beat <= beat_nxt;
      if (!stall) begin
        s1_valid <= accept;
        if (accept) begin
          s1_sum   <= sum_c;
          s1_first <= in_first;
          s1_accu  <= in_accu;
          s1_last  <= in_last;
        end
      end
      if (s1_valid && !stall && !cfg_mode) begin
        acc <= acc_nxt;
        ovf <= ovf_nxt;
      end
      if (snapshot) begin
        buf_data <= snap_data;
        buf_ovf  <= snap_ovf;
      end
    end
  end

endmodule

// File: tb/tb_pe_accu_lanes.sv
// Scoreboard bench for pe_accu_lanes (LANES=4, IN_W=16, ACC_W=24, OUT_PAR=1).
module tb_pe_accu_lanes;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_mode;
  logic [1:0]        cfg_preci;
  logic              in_valid;
  logic              in_ready;
  logic [127:0]      in_data;
  logic              in_first, in_accu, in_last;
  logic              out_valid;
  logic              out_ready;
  logic [23:0]       out_data;
  logic [1:0]        out_beat;
  logic              out_last;
  logic [0:0]        out_ovf;
  logic              busy;

  typedef struct {
    logic [23:0] data;
    logic [1:0]  beat;
    logic        last;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  pe_accu_lanes #(.LANES(4), .IN_W(16), .ACC_W(24), .OUT_PAR(1)) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_preci(cfg_preci),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_first(in_first), .in_accu(in_accu), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_beat(out_beat), .out_last(out_last), .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_result(input logic [3:0][23:0] d, input logic [3:0] ov);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.data = d[k];
      e.beat = 2'(k);
      e.last = (k == 3);
      e.ovf  = ov[k];
      exp_q.push_back(e);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [3:0][15:0] hi, input logic [3:0][15:0] lo,
                      input logic f, input logic a, input logic l);
    bit ok = 1'b0;
    in_data  = {hi, lo};
    in_first = f;
    in_accu  = a;
    in_last  = l;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_wait();
    bit ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_done", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every handshake and checks held outputs under backpressure.
  initial begin
    exp_t e;
    logic        held_valid = 1'b0;
    logic [27:0] held;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_valid = 1'b0;
      end else begin
        if (held_valid && out_valid)
          check("hold_stable", 32'({out_data, out_beat, out_last, out_ovf}), 32'(held));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'(out_data), 32'hDEAD);
          end else begin
            e = exp_q.pop_front();
            check("out_data", 32'(out_data), 32'(e.data));
            check("out_beat", 32'(out_beat), 32'(e.beat));
            check("out_last", 32'(out_last), 32'(e.last));
            check("out_ovf",  32'(out_ovf),  32'(e.ovf));
          end
        end
        held_valid = out_valid && !out_ready;
        held       = {out_data, out_beat, out_last, out_ovf};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][15:0] hi, lo;
    int cnt;
    rst = 1'b1; cfg_mode = 1'b0; cfg_preci = 2'b01; in_valid = 1'b0;
    in_data = '0; in_first = 1'b0; in_accu = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_beat",  32'(out_beat),  32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    @(posedge clk); #1;

    // preci=01 accumulate over three beats: lane k sums 16+2+k, three times.
    hi = {16'd1, 16'd1, 16'd1, 16'd1};
    lo = {16'd5, 16'd4, 16'd3, 16'd2};
    push_result({24'd63, 24'd60, 24'd57, 24'd54}, 4'b0000);
    send(hi, lo, 1'b1, 1'b0, 1'b0);
    send(hi, lo, 1'b0, 1'b1, 1'b0);
    send(hi, lo, 1'b0, 1'b1, 1'b1);
    idle_wait();

    // preci=00: plain sign-extended sums, including extremes.
    cfg_preci = 2'b00;
    hi = {16'h7FFF, 16'h8000, 16'h0003, 16'hFFFF};
    lo = {16'h7FFF, 16'h8000, 16'hFFFE, 16'h0001};
    push_result({24'h00FFFE, 24'hFF0000, 24'h000001, 24'h000000}, 4'b0000);
    send(hi, lo, 1'b1, 1'b0, 1'b1);
    idle_wait();

    // Saturation both ways, then a first beat clears the sticky flag.
    cfg_preci = 2'b01;
    hi = {16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    lo = {16'hFFF0, 16'h000F, 16'h000F, 16'h000F};
    push_result({24'h800000, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF}, 4'b1111);
    send(hi, lo, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) send(hi, lo, 1'b0, 1'b1, 1'b0);
    send(hi, lo, 1'b0, 1'b1, 1'b1);
    idle_wait();
    hi = {16'd1, 16'd1, 16'd1, 16'd1};
    lo = {16'd2, 16'd2, 16'd2, 16'd2};
    push_result({24'd18, 24'd18, 24'd18, 24'd18}, 4'b0000);
    send(hi, lo, 1'b1, 1'b0, 1'b1);
    idle_wait();

    // A beat with neither first nor accu leaves the accumulator alone.
    hi = '0;
    push_result({24'd12, 24'd12, 24'd12, 24'd12}, 4'b0000);
    send(hi, {16'd5, 16'd5, 16'd5, 16'd5}, 1'b1, 1'b0, 1'b0);
    send(hi, {16'd100, 16'd100, 16'd100, 16'd100}, 1'b0, 1'b0, 1'b0);
    send(hi, {16'd7, 16'd7, 16'd7, 16'd7}, 1'b0, 1'b1, 1'b1);
    idle_wait();

    // Bypass mode under backpressure.
    cfg_mode  = 1'b1;
    out_ready = 1'b0;
    push_result({24'd13, 24'd12, 24'd11, 24'd10}, 4'b0000);
    push_result({24'd23, 24'd22, 24'd21, 24'd20}, 4'b0000);
    push_result({24'hFFFFFF, 24'd32, 24'd31, 24'd30}, 4'b0000);
    fork
      begin
        send(hi, {16'd13, 16'd12, 16'd11, 16'd10}, 1'b0, 1'b0, 1'b0);
        send(hi, {16'd23, 16'd22, 16'd21, 16'd20}, 1'b0, 1'b0, 1'b0);
        send(hi, {16'hFFFF, 16'd32, 16'd31, 16'd30}, 1'b0, 1'b0, 1'b0);
      end
      begin
        repeat (8) @(negedge clk);
        check("bp_in_ready",  32'(in_ready),  32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_out_beat",  32'(out_beat),  32'd0);
        check("bp_out_data",  32'(out_data),  32'd10);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle_wait();
    cfg_mode = 1'b0;

    // Back-to-back results drain without an idle cycle.
    push_result({24'd4, 24'd3, 24'd2, 24'd1}, 4'b0000);
    push_result({24'd103, 24'd102, 24'd101, 24'd100}, 4'b0000);
    push_result({24'd203, 24'd202, 24'd201, 24'd200}, 4'b0000);
    fork
      begin
        send(hi, {16'd4, 16'd3, 16'd2, 16'd1}, 1'b1, 1'b0, 1'b1);
        send(hi, {16'd103, 16'd102, 16'd101, 16'd100}, 1'b1, 1'b0, 1'b1);
        send(hi, {16'd203, 16'd202, 16'd201, 16'd200}, 1'b1, 1'b0, 1'b1);
      end
      begin
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        cnt = 0;
        repeat (12) begin
          if (out_valid) cnt++;
          @(negedge clk);
        end
        check("b2b_valid_cycles", 32'(cnt), 32'd12);
      end
    join
    idle_wait();

    // Reset mid-drain discards the buffer and clears the accumulators.
    out_ready = 1'b0;
    send(hi, {16'd9, 16'd9, 16'd9, 16'd9}, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy",      32'(busy),      32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    push_result({24'd6, 24'd5, 24'd4, 24'd3}, 4'b0000);
    send(hi, {16'd6, 16'd5, 16'd4, 16'd3}, 1'b0, 1'b1, 1'b1);
    idle_wait();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
